mc_ctrl_fsm: RTL
================

# mc_ctrl_fsm

Registered multi-cycle MIPS control unit that owns its own state register and drives every datapath control strobe of the multi-cycle CPU. Beyond the base lw/sw/R-type/beq/j set, it adds bne, jal, jr and I-type ALU operations (addi/andi/ori/slti). It adds an optional memory-ready handshake and an optional illegal-opcode trap. It sits between the instruction register (OP/Funct) and the PC, memory, register-file and ALU muxes.

## Interface
Parameters:
- MEM_WAIT, 0: 1 = FETCH/MEMRD/MEMWR hold until mem_ready=1; 0 = mem_ready ignored, one cycle each.
- TRAP_EN, 1: 1 = undefined opcode enters sticky TRAP; 0 = undefined opcode returns to FETCH (NOP).

Ports:
- clk  in  1  clock. One clock domain; all state changes occur on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- OP  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- mem_ready  in  1  memory access completes this cycle.
- PCWr, PCWrCond, PCWrCondNE  out  1 each  unconditional / branch-if-zero / branch-if-not-zero PC write.
- IorD, MemRd, MemWr, IRWr  out  1 each  memory address select, read, write, IR load.
- MemtoReg  out  2  register write data: 00 ALUOut, 01 MDR, 10 PC.
- PCSrc  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target, 11 A reg.
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded, 11 OP-decoded immediate.
- ALUSrcB  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2.
- ALUSrcA, RegWr  out  1 each  ALUSrcA: 0 PC, 1 A; RegWr: register-file write enable.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- Trap  out  1  high while in TRAP.
- Done  out  1  high in the final cycle of each instruction.
- S  out  4  current state, for debug.

## Operation
- States (S encoding): 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB, 8 BEQ, 9 JUMP, 10 IEXEC, 11 IWB, 12 BNE, 13 JAL, 14 JR, 15 TRAP.
- Outputs are a Moore decode of S. Any output not listed for a state is 0.
- FETCH: MemRd=1, IRWr=1, PCWr=1, ALUSrcB=01. With MEM_WAIT=1, IRWr and PCWr are ANDed with mem_ready.
- DECODE: ALUSrcB=11. This computes the branch target.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: MemRd=1, IorD=1.
- MEMWB: RegWr=1, MemtoReg=01, Done=1.
- MEMWR: MemWr=1, IorD=1. Done=1 (gated by mem_ready when MEM_WAIT=1).
- EXEC: ALUSrcA=1, ALUOp=10.
- RWB: RegWr=1, RegDst=01, Done=1.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11.
- IWB: RegWr=1, Done=1.
- BEQ and BNE: ALUSrcA=1, ALUOp=01, PCSrc=01, Done=1. BEQ asserts PCWrCond=1; BNE asserts PCWrCondNE=1.
- JUMP: PCWr=1, PCSrc=10, Done=1.
- JAL: PCWr=1, PCSrc=10, RegWr=1, RegDst=10, MemtoReg=10, Done=1. The register file captures PC+4 on the same edge the PC updates.
- JR: PCWr=1, PCSrc=11, Done=1.
- TRAP: Trap=1.
- Transitions:
  - FETCH→DECODE (held while MEM_WAIT && !mem_ready).
  - DECODE by OP:
    - 100011 or 101011 → MEMADR.
    - 000000 → JR if Funct=001000, else EXEC.
    - 000100 → BEQ; 000101 → BNE.
    - 000010 → JUMP; 000011 → JAL.
    - 001000, 001100, 001101, 001010 → IEXEC.
    - Anything else → TRAP if TRAP_EN, else FETCH.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD → MEMWB (held while waiting). MEMWR → FETCH (held while waiting).
  - EXEC→RWB, IEXEC→IWB.
  - All Done states → FETCH.
  - TRAP → TRAP until rst.
- MemRd and MemWr stay asserted for every wait cycle. IorD stays stable during waits.

## Timing
- rst asserted: S=0 (FETCH) immediately, without waiting for a clock edge. While rst=1, every control output and Done/Trap are forced to 0.
- First FETCH is the first rising edge after rst deasserts.
- Cycles per instruction with MEM_WAIT=0:
  - lw 5.
  - sw, R-type, I-ALU 4.
  - beq, bne, j, jal, jr 3.
- With MEM_WAIT=1, add the number of cycles mem_ready is low in FETCH, MEMRD and MEMWR.
- OP and Funct are sampled only in DECODE and MEMADR. They must be stable from the IRWr edge onward.
- rst mid-instruction aborts it: no partial write strobes are emitted after the async assertion.

## Test plan
- Reset: assert rst mid-EXEC → S=0 and all outputs 0 at once. Release rst → FETCH strobes: MemRd=1, IRWr=1, PCWr=1, ALUSrcB=01.
- lw (OP=100011), MEM_WAIT=0 → S sequence 0,1,2,3,4,0. MEMWB has RegWr=1, MemtoReg=01, Done=1.
- sw, MEM_WAIT=1, mem_ready low 3 cycles in MEMWR → MemWr=1 for 4 cycles. Done only on the ready cycle, then FETCH.
- Branch/jump set:
  - bne (000101) → S 0,1,12: PCWrCondNE=1, PCSrc=01.
  - jal (000011) → S 13: PCWr=1, RegWr=1, RegDst=10, MemtoReg=10.
  - jr (OP=0, Funct=001000) → S 14: PCSrc=11.
- ori (001101) → S 0,1,10,11. IEXEC has ALUOp=11, ALUSrcB=10. IWB has RegWr=1, RegDst=00.
- Illegal OP=111111:
  - TRAP_EN=1 → S=15, Trap=1, held 20 cycles until rst.
  - TRAP_EN=0 → DECODE→FETCH with no write strobe asserted.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: Moore FSM that sequences fetch/decode/execute
// and drives every datapath strobe, with optional memory wait and illegal-op trap.
module mc_ctrl_fsm #(
  parameter bit MEM_WAIT = 1'b0,
  parameter bit TRAP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWr,
  output logic       PCWrCond,
  output logic       PCWrCondNE,
  output logic       IorD,
  output logic       MemRd,
  output logic       MemWr,
  output logic       IRWr,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       RegWr,
  output logic [1:0] RegDst,
  output logic       Trap,
  output logic       Done,
  output logic [3:0] S
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
    BEQ    = 4'd8,  JUMP   = 4'd9,  IEXEC  = 4'd10, IWB   = 4'd11,
    BNE    = 4'd12, JAL    = 4'd13, JR     = 4'd14, TRAP  = 4'd15
  } stateT;

  stateT state, nextState;
  logic  memOk;

  assign memOk = !MEM_WAIT || mem_ready;
  assign S     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      FETCH:  if (memOk) nextState = DECODE;
      DECODE: begin
        case (OP)
          6'b100011, 6'b101011: nextState = MEMADR;
          6'b000000: nextState = (Funct == 6'b001000) ? JR : EXEC;
          6'b000100: nextState = BEQ;
          6'b000101: nextState = BNE;
          6'b000010: nextState = JUMP;
          6'b000011: nextState = JAL;
          6'b001000, 6'b001100, 6'b001101, 6'b001010: nextState = IEXEC;
          default:   nextState = TRAP_EN ? TRAP : FETCH;
        endcase
      end
      MEMADR: nextState = (OP == 6'b100011) ? MEMRD : MEMWR;
      MEMRD:  if (memOk) nextState = MEMWB;
      MEMWR:  if (memOk) nextState = FETCH;
      EXEC:   nextState = RWB;
      IEXEC:  nextState = IWB;
      TRAP:   nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Reset overrides the decode so no strobe leaks out while rst is held.
  always_comb begin
    PCWr = 1'b0; PCWrCond = 1'b0; PCWrCondNE = 1'b0;
    IorD = 1'b0; MemRd = 1'b0; MemWr = 1'b0; IRWr = 1'b0;
    MemtoReg = 2'b00; PCSrc = 2'b00; ALUOp = 2'b00; ALUSrcB = 2'b00;
    ALUSrcA = 1'b0; RegWr = 1'b0; RegDst = 2'b00; Trap = 1'b0; Done = 1'b0;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          MemRd = 1'b1; IRWr = memOk; PCWr = memOk; ALUSrcB = 2'b01;
        end
        DECODE: ALUSrcB = 2'b11;
        MEMADR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
        MEMRD:  begin MemRd = 1'b1; IorD = 1'b1; end
        MEMWB:  begin RegWr = 1'b1; MemtoReg = 2'b01; Done = 1'b1; end
        MEMWR:  begin MemWr = 1'b1; IorD = 1'b1; Done = memOk; end
        EXEC:   begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
        RWB:    begin RegWr = 1'b1; RegDst = 2'b01; Done = 1'b1; end
        IEXEC:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b11; end
        IWB:    begin RegWr = 1'b1; Done = 1'b1; end
        BEQ: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; PCWrCond = 1'b1; Done = 1'b1;
        end
        BNE: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; PCWrCondNE = 1'b1; Done = 1'b1;
        end
        JUMP:   begin PCWr = 1'b1; PCSrc = 2'b10; Done = 1'b1; end
        JAL: begin
          PCWr = 1'b1; PCSrc = 2'b10; RegWr = 1'b1; RegDst = 2'b10;
          MemtoReg = 2'b10; Done = 1'b1;
        end
        JR:     begin PCWr = 1'b1; PCSrc = 2'b11; Done = 1'b1; end
        TRAP:   Trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
